// File: rtl/airlock_sequencer_if.sv
// Handshake bundle between the airlock sequencer, the pump units and the operator-request logic.
// The slave modport is the sequencer's view; the master modport is its environment.
interface airlock_sequencer_if;
    logic       fill_req;
    logic       evac_req;
    logic       pressurizing;
    logic       depressurizing;
    logic       press_start;
    logic       depress_start;
    logic       inner_open;
    logic       outer_open;
    logic       busy;
    logic       fault;
    logic [2:0] state;

    modport slave (
        input  fill_req, evac_req, pressurizing, depressurizing,
        output press_start, depress_start, inner_open, outer_open, busy, fault, state
    );

    modport master (
        output fill_req, evac_req, pressurizing, depressurizing,
        input  press_start, depress_start, inner_open, outer_open, busy, fault, state
    );
endinterface

// File: rtl/airlock_sequencer.sv
// Airlock chamber sequencer: door interlock plus pressurize/vent start handshakes.
// Define AIRLOCK_WATCHDOG_EN to bound the pump waits and enable the sticky FAULT state.
module airlock_sequencer #(
    parameter int DOOR_CYCLES  = 4,
    parameter int ACK_TIMEOUT  = 8,
    parameter int BUSY_TIMEOUT = 1024
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    airlock_sequencer_if.slave   bus
);

    localparam int MAX_AB = (ACK_TIMEOUT > BUSY_TIMEOUT) ? ACK_TIMEOUT : BUSY_TIMEOUT;
    localparam int MAXC   = (DOOR_CYCLES > MAX_AB) ? DOOR_CYCLES : MAX_AB;
    localparam int CW     = $clog2(MAXC) + 1;

    typedef enum logic [2:0] {
        SEALED     = 3'd0,
        SETTLE     = 3'd1,
        START      = 3'd2,
        WAIT_ACK   = 3'd3,
        WAIT_DONE  = 3'd4,
        PRESS_OPEN = 3'd5,
        VAC_OPEN   = 3'd6,
        FAULT      = 3'd7
    } state_e;

    state_e          state_q, state_d;
    logic            dir_q, dir_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            press_start_q, press_start_d;
    logic            depress_start_q, depress_start_d;
    logic            inner_open_q, inner_open_d;
    logic            outer_open_q, outer_open_d;
    logic            busy_q, busy_d;
    logic            fault_q, fault_d;
    logic            ack;

    // Only the busy flag of the selected pump counts as acknowledge/completion.
    assign ack = dir_q ? bus.pressurizing : bus.depressurizing;

    always_comb begin
        state_d = state_q;
        dir_d   = dir_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            SEALED: begin
                if (bus.fill_req) begin
                    state_d = SETTLE;
                    dir_d   = 1'b1;
                    cnt_d   = CW'(DOOR_CYCLES - 1);
                end else if (bus.evac_req) begin
                    state_d = SETTLE;
                    dir_d   = 1'b0;
                    cnt_d   = CW'(DOOR_CYCLES - 1);
                end
            end
            SETTLE: begin
                if (cnt_q == '0) state_d = START;
                else             cnt_d   = cnt_q - CW'(1);
            end
            START: begin
                state_d = WAIT_ACK;
`ifdef AIRLOCK_WATCHDOG_EN
                cnt_d   = CW'(ACK_TIMEOUT - 1);
`endif
            end
            WAIT_ACK: begin
`ifdef AIRLOCK_WATCHDOG_EN
                if (ack) begin
                    state_d = WAIT_DONE;
                    cnt_d   = CW'(BUSY_TIMEOUT - 1);
                end else if (cnt_q == '0) begin
                    state_d = FAULT;
                end else begin
                    cnt_d   = cnt_q - CW'(1);
                end
`else
                if (ack) state_d = WAIT_DONE;
`endif
            end
            WAIT_DONE: begin
                if (!ack) begin
                    state_d = dir_q ? PRESS_OPEN : VAC_OPEN;
`ifdef AIRLOCK_WATCHDOG_EN
                end else if (cnt_q == '0) begin
                    state_d = FAULT;
                end else begin
                    cnt_d   = cnt_q - CW'(1);
`endif
                end
            end
            PRESS_OPEN: begin
                if (bus.evac_req) begin
                    state_d = SETTLE;
                    dir_d   = 1'b0;
                    cnt_d   = CW'(DOOR_CYCLES - 1);
                end
            end
            VAC_OPEN: begin
                if (bus.fill_req) begin
                    state_d = SETTLE;
                    dir_d   = 1'b1;
                    cnt_d   = CW'(DOOR_CYCLES - 1);
                end
            end
            FAULT: begin
`ifdef AIRLOCK_WATCHDOG_EN
                state_d = FAULT;
`else
                state_d = SEALED;
`endif
            end
            default: state_d = SEALED;
        endcase
    end

    // Outputs are decoded from the next state so every output is a flop aligned with state_q.
    always_comb begin
        press_start_d   = (state_d == START) &&  dir_d;
        depress_start_d = (state_d == START) && !dir_d;
        inner_open_d    = (state_d == PRESS_OPEN);
        outer_open_d    = (state_d == VAC_OPEN);
        busy_d          = (state_d == SETTLE) || (state_d == START) ||
                          (state_d == WAIT_ACK) || (state_d == WAIT_DONE);
        fault_d         = (state_d == FAULT);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q         <= SEALED;
            dir_q           <= 1'b0;
            cnt_q           <= '0;
            press_start_q   <= 1'b0;
            depress_start_q <= 1'b0;
            inner_open_q    <= 1'b0;
            outer_open_q    <= 1'b0;
            busy_q          <= 1'b0;
            fault_q         <= 1'b0;
        end else begin
            state_q         <= state_d;
            dir_q           <= dir_d;
            cnt_q           <= cnt_d;
            press_start_q   <= press_start_d;
            depress_start_q <= depress_start_d;
            inner_open_q    <= inner_open_d;
            outer_open_q    <= outer_open_d;
            busy_q          <= busy_d;
            fault_q         <= fault_d;
        end
    end

    assign bus.press_start   = press_start_q;
    assign bus.depress_start = depress_start_q;
    assign bus.inner_open    = inner_open_q;
    assign bus.outer_open    = outer_open_q;
    assign bus.busy          = busy_q;
    assign bus.fault         = fault_q;
    assign bus.state         = state_q;

endmodule
